// File: rtl/irq_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_cond_pkg
//  Purpose  : Shared constants for the interrupt source conditioner:
//             APB register word addresses, glitch-filter counter width and
//             the legal synchroniser depth range.
//  Revision : 1.0  initial release
// ============================================================================
package irq_cond_pkg;

    // Register word addresses (PADDR[5:2])
    localparam logic [3:0] MODEA    = 4'h0;
    localparam logic [3:0] POLA     = 4'h1;
    localparam logic [3:0] PENDA    = 4'h2;
    localparam logic [3:0] RAWA     = 4'h3;
    localparam logic [3:0] FILTERA  = 4'h4;

    // Glitch-filter length / counter width
    localparam int FILTERW = 4;

    // Legal synchroniser depth
    localparam int SYNCMIN = 2;
    localparam int SYNCMAX = 3;

endpackage : irq_cond_pkg
`default_nettype wire

// File: rtl/irq_cond_channel.sv
`default_nettype none
// ============================================================================
//  Module   : irq_cond_channel
//  Purpose  : One conditioned interrupt source: synchroniser, polarity
//             correction, glitch filter, rising-edge detect, pending bit and
//             registered output.
//  Ports    : PCLK, PRESETn      clock, async active-low reset
//             i_srcIn            raw asynchronous source
//             i_mode             MODE bit as it will be after this edge
//                                (1 = edge/pending, 0 = level)
//             i_polarity         1 = source is active-low
//             i_filter           shared glitch-filter length
//             i_clrPend          write-1-to-clear strobe for the pending bit
//             o_asserted         synchroniser output XOR polarity (RAWSTAT)
//             o_pending          pending bit
//             o_irqOut           conditioned, active-high, registered output
//  Revision : 1.0  initial release
// ============================================================================
module irq_cond_channel
    import irq_cond_pkg::*;
#(
    parameter int SYNCSTAGES = 2
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic               i_srcIn,
    input  logic               i_mode,
    input  logic               i_polarity,
    input  logic [FILTERW-1:0] i_filter,
    input  logic               i_clrPend,
    output logic               o_asserted,
    output logic               o_pending,
    output logic               o_irqOut
);

    logic [SYNCSTAGES-1:0] r_sync;
    logic                  r_filt;
    logic                  r_filtPrev;
    logic [FILTERW-1:0]    r_cnt;
    logic                  r_pend;
    logic                  r_irq;

    logic                  w_asserted;
    logic                  w_filtNext;
    logic [FILTERW-1:0]    w_cntNext;
    logic                  w_rise;
    logic                  w_pendNext;

    assign w_asserted = r_sync[SYNCSTAGES-1] ^ i_polarity;

    // Filter: the counter runs only while the input differs from the filtered
    // value. Using >= lets a FILTER reduced mid-count take effect at once
    // instead of letting the counter run past the new limit.
    always_comb begin
        w_filtNext = r_filt;
        w_cntNext  = r_cnt;
        if (w_asserted == r_filt) begin
            w_cntNext = '0;
        end else if (r_cnt >= i_filter) begin
            w_filtNext = w_asserted;
            w_cntNext  = '0;
        end else begin
            w_cntNext = r_cnt + 4'd1;
        end
    end

    assign w_rise = r_filt & ~r_filtPrev;

    // Set beats clear so an edge arriving with a clear-write is not lost.
    // Level mode holds the pending bit at zero.
    assign w_pendNext = i_mode ? ((r_pend & ~i_clrPend) | w_rise) : 1'b0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_sync     <= '0;
            r_filt     <= 1'b0;
            r_filtPrev <= 1'b0;
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNCSTAGES-2:0], i_srcIn};
            r_filt     <= w_filtNext;
            r_filtPrev <= r_filt;
            r_cnt      <= w_cntNext;
            r_pend     <= w_pendNext;
            r_irq      <= i_mode ? w_pendNext : w_filtNext;
        end
    end

    assign o_asserted = w_asserted;
    assign o_pending  = r_pend;
    assign o_irqOut   = r_irq;

endmodule : irq_cond_channel
`default_nettype wire

// File: rtl/irq_source_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : irq_source_conditioner
//  Purpose  : APB-configurable conditioning stage in front of the interrupt
//             controller. Holds the APB decode, the shared MODE / POLARITY /
//             FILTER registers and the PRDATA mux; one irq_cond_channel per
//             source does the per-source pipeline.
//  Ports    : PCLK, PRESETn                  APB clock, async active-low reset
//             PSEL, PENABLE, PWRITE, PADDR,
//             PWDATA                         APB request (zero-wait)
//             PRDATA                         registered read data
//             srcIn [NUMSRC]                 raw asynchronous sources
//             irqOut[NUMSRC]                 conditioned active-high sources
//  Params   : NUMSRC 1..32, SYNCSTAGES 2..3
//  Revision : 1.0  initial release
// ============================================================================
module irq_source_conditioner
    import irq_cond_pkg::*;
#(
    parameter int NUMSRC     = 8,
    parameter int SYNCSTAGES = 2
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [5:2]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    input  logic [NUMSRC-1:0] srcIn,
    output logic [NUMSRC-1:0] irqOut
);

    logic [NUMSRC-1:0]  r_mode;
    logic [NUMSRC-1:0]  r_pol;
    logic [FILTERW-1:0] r_filter;

    logic               w_wr;
    logic               w_rd;
    logic [NUMSRC-1:0]  w_modeNext;
    logic [NUMSRC-1:0]  w_clr;
    logic [NUMSRC-1:0]  w_pend;
    logic [NUMSRC-1:0]  w_raw;
    logic [31:0]        w_rdata;
    logic               w_unusedPwdata;

    // Registers are written and read in the setup phase.
    assign w_wr = PSEL &  PWRITE & ~PENABLE;
    assign w_rd = PSEL & ~PWRITE & ~PENABLE;

    // Upper PWDATA bits are only meaningful for wide configurations.
    assign w_unusedPwdata = ^PWDATA;

    // The channels see MODE's next value so an edge-to-level switch clears
    // the pending bit on the very edge of the write.
    always_comb begin
        w_modeNext = r_mode;
        w_clr      = '0;
        if (w_wr) begin
            case (PADDR)
                MODEA:   w_modeNext = PWDATA[NUMSRC-1:0];
                PENDA:   w_clr      = PWDATA[NUMSRC-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (PADDR)
            MODEA:   w_rdata[NUMSRC-1:0]  = r_mode;
            POLA:    w_rdata[NUMSRC-1:0]  = r_pol;
            PENDA:   w_rdata[NUMSRC-1:0]  = w_pend;
            RAWA:    w_rdata[NUMSRC-1:0]  = w_raw;
            FILTERA: w_rdata[FILTERW-1:0] = r_filter;
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_mode   <= '0;
            r_pol    <= '0;
            r_filter <= '0;
            PRDATA   <= '0;
        end else begin
            r_mode <= w_modeNext;
            if (w_wr && (PADDR == POLA)) begin
                r_pol <= PWDATA[NUMSRC-1:0];
            end
            if (w_wr && (PADDR == FILTERA)) begin
                r_filter <= PWDATA[FILTERW-1:0];
            end
            // PRDATA is zero outside the cycle after a read setup.
            PRDATA <= w_rd ? w_rdata : 32'd0;
        end
    end

    for (genvar i = 0; i < NUMSRC; i++) begin : g_chan
        irq_cond_channel #(
            .SYNCSTAGES (SYNCSTAGES)
        ) u_chan (
            .PCLK       (PCLK),
            .PRESETn    (PRESETn),
            .i_srcIn    (srcIn[i]),
            .i_mode     (w_modeNext[i]),
            .i_polarity (r_pol[i]),
            .i_filter   (r_filter),
            .i_clrPend  (w_clr[i]),
            .o_asserted (w_raw[i]),
            .o_pending  (w_pend[i]),
            .o_irqOut   (irqOut[i])
        );
    end

endmodule : irq_source_conditioner
`default_nettype wire
